// File: rtl/bp_me_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : bp_me_wb_master_bridge
// Description : Converts single-beat BedRock forward messages into one
//               classic (non-burst) Wishbone B4 cycle each, and returns one
//               single-beat reverse message per Wishbone acknowledge.
//               One transaction in flight at a time.
// Ports       : clk_i/reset_i          - clock, synchronous active-high reset
//               mem_fwd_*              - forward stream in (header/data/v/ready/last)
//               mem_rev_*              - reverse stream out (header/data/v/ready/last)
//               adr_o..bte_o, ack_i, dat_i - Wishbone classic master port
// Revision    : 1.0 - initial release
// ============================================================================
module bp_me_wb_master_bridge #(
    parameter  int paddr_width_p   = 40,
    parameter  int data_width_p    = 64,
    parameter  int payload_width_p = 16,
    localparam int hdr_width_lp    = 4 + 3 + paddr_width_p + payload_width_p,
    localparam int wb_adr_width_lp = paddr_width_p - 3,
    localparam int wb_sel_width_lp = data_width_p / 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic [hdr_width_lp-1:0]    mem_fwd_header_i,
    input  logic [data_width_p-1:0]    mem_fwd_data_i,
    input  logic                       mem_fwd_v_i,
    output logic                       mem_fwd_ready_and_o,
    input  logic                       mem_fwd_last_i,

    output logic [hdr_width_lp-1:0]    mem_rev_header_o,
    output logic [data_width_p-1:0]    mem_rev_data_o,
    output logic                       mem_rev_v_o,
    input  logic                       mem_rev_ready_and_i,
    output logic                       mem_rev_last_o,

    output logic [wb_adr_width_lp-1:0] adr_o,
    output logic [data_width_p-1:0]    dat_o,
    output logic                       cyc_o,
    output logic                       stb_o,
    output logic [wb_sel_width_lp-1:0] sel_o,
    output logic                       we_o,
    output logic [2:0]                 cti_o,
    output logic [1:0]                 bte_o,
    input  logic                       ack_i,
    input  logic [data_width_p-1:0]    dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_REV  = 2'd2
    } state_e;

    state_e                     state_q;
    logic [hdr_width_lp-1:0]    hdr_q;
    logic [wb_adr_width_lp-1:0] adr_q;
    logic [data_width_p-1:0]    dat_q;
    logic [wb_sel_width_lp-1:0] sel_q;
    logic                       we_q;
    logic                       cyc_q;
    logic                       rev_v_q;
    logic [data_width_p-1:0]    rev_data_q;
    logic [2:0]                 off_q;
    logic [1:0]                 lg_q;

    // Last is always asserted by the producer; it carries no information here.
    logic unused_last;
    assign unused_last = mem_fwd_last_i;

    // Forward header fields: {payload, size, addr, msg_type}
    logic [3:0]               fwd_type;
    logic [paddr_width_p-1:0] fwd_addr;
    logic [2:0]               fwd_size;
    assign fwd_type = mem_fwd_header_i[3:0];
    assign fwd_addr = mem_fwd_header_i[4 +: paddr_width_p];
    assign fwd_size = mem_fwd_header_i[4+paddr_width_p +: 3];

    // log2 of the access size; any size code above 3 is a full dword
    logic [1:0]                 lg_d;
    logic [2:0]                 off_d;
    logic [wb_sel_width_lp-1:0] mask_d;
    logic [wb_sel_width_lp-1:0] sel_d;
    logic                       we_d;

    assign lg_d = fwd_size[2] ? 2'd3 : fwd_size[1:0];
    assign we_d = (fwd_type == 4'd1) || (fwd_type == 4'd3);

    // Offset is forced to natural alignment by dropping the sub-size bits
    always_comb begin
        off_d  = 3'd0;
        mask_d = 8'hFF;
        unique case (lg_d)
            2'd0: begin off_d = fwd_addr[2:0];          mask_d = 8'h01; end
            2'd1: begin off_d = {fwd_addr[2:1], 1'b0};  mask_d = 8'h03; end
            2'd2: begin off_d = {fwd_addr[2], 2'b00};   mask_d = 8'h0F; end
            default: begin off_d = 3'd0;                mask_d = 8'hFF; end
        endcase
    end

    assign sel_d = mask_d << off_d;

    // Replicate the lowest 2^lg bytes of v across the full dword
    function automatic logic [63:0] replicate(input logic [63:0] v, input logic [1:0] lg);
        logic [63:0] r;
        unique case (lg)
            2'd0:    r = {8{v[7:0]}};
            2'd1:    r = {4{v[15:0]}};
            2'd2:    r = {2{v[31:0]}};
            default: r = v;
        endcase
        return r;
    endfunction

    // Read data is brought down to byte lane 0 before replication
    logic [data_width_p-1:0] rd_shift_d;
    assign rd_shift_d = dat_i >> {off_q, 3'b000};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            hdr_q      <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            rev_v_q    <= 1'b0;
            rev_data_q <= '0;
            off_q      <= 3'd0;
            lg_q       <= 2'd0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Ready is implied here: IDLE and reset deasserted
                    if (mem_fwd_v_i) begin
                        hdr_q   <= mem_fwd_header_i;
                        adr_q   <= fwd_addr[paddr_width_p-1:3];
                        sel_q   <= sel_d;
                        we_q    <= we_d;
                        dat_q   <= replicate(mem_fwd_data_i, lg_d);
                        off_q   <= off_d;
                        lg_q    <= lg_d;
                        cyc_q   <= 1'b1;
                        state_q <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (ack_i) begin
                        cyc_q      <= 1'b0;
                        rev_v_q    <= 1'b1;
                        rev_data_q <= we_q ? '0 : replicate(rd_shift_d, lg_q);
                        state_q    <= ST_REV;
                    end
                end
                ST_REV: begin
                    if (mem_rev_ready_and_i) begin
                        rev_v_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    cyc_q   <= 1'b0;
                    rev_v_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_fwd_ready_and_o = (state_q == ST_IDLE) & ~reset_i;

    assign mem_rev_header_o = hdr_q;
    assign mem_rev_data_o   = rev_data_q;
    assign mem_rev_v_o      = rev_v_q;
    assign mem_rev_last_o   = rev_v_q;

    assign adr_o = adr_q;
    assign dat_o = dat_q;
    assign cyc_o = cyc_q;
    assign stb_o = cyc_q;
    assign sel_o = sel_q;
    assign we_o  = we_q;
    assign cti_o = 3'b000;
    assign bte_o = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_bp_me_wb_master_bridge
// Description : Directed self-checking bench for bp_me_wb_master_bridge.
//               A transaction-level model tracks the expected phase and the
//               expected Wishbone / reverse fields; a negedge process checks
//               the DUT against it every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bp_me_wb_master_bridge;

    localparam int PA = 40;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [62:0] mem_fwd_header_i;
    logic [63:0] mem_fwd_data_i;
    logic        mem_fwd_v_i;
    logic        mem_fwd_ready_and_o;
    logic        mem_fwd_last_i;
    logic [62:0] mem_rev_header_o;
    logic [63:0] mem_rev_data_o;
    logic        mem_rev_v_o;
    logic        mem_rev_ready_and_i;
    logic        mem_rev_last_o;
    logic [36:0] adr_o;
    logic [63:0] dat_o;
    logic        cyc_o;
    logic        stb_o;
    logic [7:0]  sel_o;
    logic        we_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic        ack_i;
    logic [63:0] dat_i;

    always #5 clk_i = ~clk_i;

    bp_me_wb_master_bridge dut (
        .clk_i               (clk_i),
        .reset_i             (reset_i),
        .mem_fwd_header_i    (mem_fwd_header_i),
        .mem_fwd_data_i      (mem_fwd_data_i),
        .mem_fwd_v_i         (mem_fwd_v_i),
        .mem_fwd_ready_and_o (mem_fwd_ready_and_o),
        .mem_fwd_last_i      (mem_fwd_last_i),
        .mem_rev_header_o    (mem_rev_header_o),
        .mem_rev_data_o      (mem_rev_data_o),
        .mem_rev_v_o         (mem_rev_v_o),
        .mem_rev_ready_and_i (mem_rev_ready_and_i),
        .mem_rev_last_o      (mem_rev_last_o),
        .adr_o               (adr_o),
        .dat_o               (dat_o),
        .cyc_o               (cyc_o),
        .stb_o               (stb_o),
        .sel_o               (sel_o),
        .we_o                (we_o),
        .cti_o               (cti_o),
        .bte_o               (bte_o),
        .ack_i               (ack_i),
        .dat_i               (dat_i)
    );

    int checks   = 0;
    int failures = 0;
    bit run      = 1'b0;
    int dut_rev  = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase: 0 waiting for forward, 1 Wishbone cycle open, 2 reverse pending
    int          phase = 0;
    logic [62:0] e_hdr;
    logic [36:0] e_adr;
    logic [7:0]  e_sel;
    logic        e_we;
    logic [63:0] e_dat;
    logic [63:0] e_rdata;
    logic [39:0] m_addr;
    logic [3:0]  m_type;
    int          e_bytes;
    int          e_off;

    function automatic int nbytes(input logic [2:0] s);
        return (s >= 3'd3) ? 8 : (1 << s);
    endfunction

    // byte i of the result is byte (i mod n) of v
    function automatic logic [63:0] spread(input logic [63:0] v, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = v[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [62:0] mk_hdr(input logic [15:0] pl, input logic [2:0] sz,
                                           input logic [39:0] a, input logic [3:0] ty);
        return {pl, sz, a, ty};
    endfunction

    always @(posedge clk_i) begin
        if (!reset_i && mem_rev_v_o && mem_rev_ready_and_i) dut_rev++;
        if (reset_i) begin
            phase = 0;
        end else if (phase == 0) begin
            if (mem_fwd_v_i) begin
                e_hdr   = mem_fwd_header_i;
                m_type  = mem_fwd_header_i[3:0];
                m_addr  = mem_fwd_header_i[43:4];
                e_bytes = nbytes(mem_fwd_header_i[46:44]);
                e_off   = int'(m_addr[2:0]);
                e_off   = e_off - (e_off % e_bytes);
                e_adr   = 37'(m_addr >> 3);
                e_sel   = 8'(((1 << e_bytes) - 1) << e_off);
                e_we    = (m_type == 4'd1) || (m_type == 4'd3);
                e_dat   = spread(mem_fwd_data_i, e_bytes);
                phase   = 1;
            end
        end else if (phase == 1) begin
            if (ack_i) begin
                e_rdata = e_we ? 64'd0 : spread(dat_i >> (8 * e_off), e_bytes);
                phase   = 2;
            end
        end else begin
            if (mem_rev_ready_and_i) phase = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin
        if (run) begin
            chk("fwd_ready", mem_fwd_ready_and_o, (phase == 0) && !reset_i);
            chk("cyc", cyc_o, phase == 1);
            chk("stb", stb_o, phase == 1);
            chk("rev_v", mem_rev_v_o, phase == 2);
            chk("rev_last", mem_rev_last_o, phase == 2);
            chk("cti", cti_o, 3'b000);
            chk("bte", bte_o, 2'b00);
            if (phase == 1) begin
                chk("adr", adr_o, e_adr);
                chk("sel", sel_o, e_sel);
                chk("we", we_o, e_we);
                if (e_we) chk("wdat", dat_o, e_dat);
            end
            if (phase == 2) begin
                chk("rev_hdr", mem_rev_header_o, e_hdr);
                chk("rev_data", mem_rev_data_o, e_rdata);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input logic [62:0] h, input logic [63:0] d);
        mem_fwd_header_i = h;
        mem_fwd_data_i   = d;
        mem_fwd_v_i      = 1'b1;
        step();
        mem_fwd_v_i      = 1'b0;
    endtask

    task automatic ack_after(input int n, input logic [63:0] d);
        repeat (n) step();
        ack_i = 1'b1;
        dat_i = d;
        step();
        ack_i = 1'b0;
        dat_i = 64'hC0FFEE00C0FFEE00;
    endtask

    task automatic take_rev(input int n);
        repeat (n) step();
        mem_rev_ready_and_i = 1'b1;
        step();
        mem_rev_ready_and_i = 1'b0;
        mem_fwd_v_i         = 1'b0;
    endtask

    logic [62:0] h;

    initial begin
        reset_i             = 1'b1;
        mem_fwd_header_i    = '0;
        mem_fwd_data_i      = '0;
        mem_fwd_v_i         = 1'b0;
        mem_fwd_last_i      = 1'b1;
        mem_rev_ready_and_i = 1'b0;
        ack_i               = 1'b0;
        dat_i               = '0;

        @(posedge clk_i);
        run = 1'b1;
        @(negedge clk_i);
        chk("rst_adr", adr_o, 37'd0);
        chk("rst_sel", sel_o, 8'd0);
        chk("rst_dat", dat_o, 64'd0);
        chk("rst_we", we_o, 1'b0);
        chk("rst_cyc", cyc_o, 1'b0);
        chk("rst_rev_v", mem_rev_v_o, 1'b0);
        step();
        reset_i = 1'b0;
        step();

        // 1: 8-byte read
        h = mk_hdr(16'hBEEF, 3'd3, 40'h80000010, 4'd0);
        send(h, 64'h0);
        chk("t1_adr", adr_o, 37'h10000002);
        chk("t1_sel", sel_o, 8'hFF);
        chk("t1_we", we_o, 1'b0);
        ack_after(2, 64'h1122334455667788);
        chk("t1_rdata", mem_rev_data_o, 64'h1122334455667788);
        chk("t1_hdr", mem_rev_header_o, {16'hBEEF, 3'd3, 40'h80000010, 4'd0});
        take_rev(0);

        // 2: 1-byte write
        h = mk_hdr(16'h1234, 3'd0, 40'h80000003, 4'd1);
        send(h, 64'h123456789ABCDEAB);
        chk("t2_sel", sel_o, 8'h08);
        chk("t2_dat", dat_o, 64'hABABABABABABABAB);
        chk("t2_we", we_o, 1'b1);
        ack_after(0, 64'hFFFFFFFFFFFFFFFF);
        chk("t2_rdata", mem_rev_data_o, 64'd0);
        take_rev(1);

        // 3: 4-byte read from upper word
        h = mk_hdr(16'h0A0A, 3'd2, 40'h80000004, 4'd0);
        send(h, 64'h0);
        chk("t3_sel", sel_o, 8'hF0);
        ack_after(1, 64'hDEADBEEF00000000);
        chk("t3_rdata", mem_rev_data_o, 64'hDEADBEEFDEADBEEF);
        take_rev(0);

        // 4: misaligned halfword read, forward pushed while busy, reverse backpressure
        h = mk_hdr(16'h5555, 3'd1, 40'h80000005, 4'd2);
        send(h, 64'h0);
        chk("t4_sel", sel_o, 8'h30);
        mem_fwd_header_i = mk_hdr(16'hFFFF, 3'd3, 40'hFFFFFFFFF8, 4'd1);
        mem_fwd_v_i      = 1'b1;
        ack_after(3, 64'h0000A1B200000000);
        chk("t4_rdata", mem_rev_data_o, 64'hA1B2A1B2A1B2A1B2);
        take_rev(5);

        // 5: oversize-coded write, ack delayed 10 cycles, then stray acks in idle
        h = mk_hdr(16'hC3C3, 3'd5, 40'h80000009, 4'd3);
        send(h, 64'h0123456789ABCDEF);
        chk("t5_adr", adr_o, 37'h10000001);
        chk("t5_sel", sel_o, 8'hFF);
        chk("t5_dat", dat_o, 64'h0123456789ABCDEF);
        ack_after(10, 64'h0);
        take_rev(0);
        ack_i = 1'b1;
        dat_i = 64'h1111111111111111;
        step();
        step();
        ack_i = 1'b0;
        chk("t5_late_ack_cyc", cyc_o, 1'b0);
        chk("t5_late_ack_v", mem_rev_v_o, 1'b0);

        // 6: reset while the Wishbone cycle is open, then a normal read
        h = mk_hdr(16'h7777, 3'd3, 40'h80000020, 4'd0);
        send(h, 64'h0);
        step();
        step();
        reset_i = 1'b1;
        step();
        chk("t6_cyc_dropped", cyc_o, 1'b0);
        chk("t6_no_rev", mem_rev_v_o, 1'b0);
        reset_i = 1'b0;
        step();
        h = mk_hdr(16'h9999, 3'd0, 40'h80000007, 4'd0);
        send(h, 64'h0);
        chk("t6_sel", sel_o, 8'h80);
        ack_after(1, 64'h5A00000000000000);
        chk("t6_rdata", mem_rev_data_o, 64'h5A5A5A5A5A5A5A5A);
        take_rev(2);

        repeat (3) step();
        chk("rev_beats", dut_rev, 6);
        run = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bp_me_wb_master_bridge.md
Name: bp_me_wb_master_bridge

Overview:
- Bridge from a BedRock-style memory forward/reverse stream to a Wishbone B4 classic master port.
- Serves one uncached core port, I$ or D$, of a unicore-lite LiteX integration.
- Each accepted single-beat forward message becomes exactly one non-burst Wishbone cycle.
- Each Wishbone acknowledge produces exactly one single-beat reverse message.

Parameters:
- paddr_width_p, 40: physical address width.
- data_width_p, 64: Wishbone and BedRock data width. Fixed at 64.
- payload_width_p, 16: opaque header payload width. Returned unchanged.
- Derived: hdr_width_lp = 4+3+paddr_width_p+payload_width_p = 63.
- Derived: wb_adr_width_lp = paddr_width_p-3 = 37.
- Derived: wb_sel_width_lp = 8.

Ports:
- clk_i  in  1  single clock.
- reset_i  in  1  synchronous, active-high reset.
- mem_fwd_header_i  in  hdr_width_lp  forward header, packed {payload, size[2:0], addr, msg_type[3:0]}; msg_type is the LSBs.
- mem_fwd_data_i  in  64  write data, LSB-aligned.
- mem_fwd_v_i  in  1  forward valid.
- mem_fwd_ready_and_o  out  1  forward ready (valid&ready handshake).
- mem_fwd_last_i  in  1  last beat. Always 1 in use; ignored.
- mem_rev_header_o  out  hdr_width_lp  reverse header.
- mem_rev_data_o  out  64  read data.
- mem_rev_v_o  out  1  reverse valid.
- mem_rev_ready_and_i  in  1  reverse ready.
- mem_rev_last_o  out  1  last beat; equals mem_rev_v_o.
- adr_o  out  37  dword address.
- dat_o  out  64  write data.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- sel_o  out  8  byte enables.
- we_o  out  1  write enable.
- cti_o  out  3  constant 3'b000 (classic cycle).
- bte_o  out  2  constant 2'b00.
- ack_i  in  1  Wishbone acknowledge.
- dat_i  in  64  Wishbone read data.

Behaviour:
- FSM states: IDLE, BUS, REV. Reset state is IDLE.
- Reset values: cyc_o=stb_o=we_o=0; mem_rev_v_o=0; sel_o=0; adr_o=0; dat_o=0.
- mem_fwd_ready_and_o = (state==IDLE) & ~reset_i.
- IDLE:
  - On mem_fwd_v_i & ready, register the header and data, then go to BUS.
- BUS:
  - cyc_o=stb_o=1, driven from registered values starting the cycle after acceptance.
  - Held stable until ack_i.
  - On ack_i: latch dat_i, go to REV. cyc_o/stb_o are 0 in the following cycle.
- REV:
  - mem_rev_v_o=1 and mem_rev_last_o=1.
  - Header equals the registered forward header, bit-exact.
  - Hold until mem_rev_ready_and_i, then go to IDLE.
- Minimum occupancy is 3 cycles per transaction. No pipelining.
- Write/read decode: msg_type 1 or 3 is a write (we_o=1). Every other code is a read (we_o=0).
- Size decode: size 0/1/2/3 = 1/2/4/8 bytes. Size 4-7 is treated as 8 bytes.
- Offset: off = addr[2:0] with the low log2(bytes) bits cleared (natural alignment forced).
- Address: adr_o = addr[paddr_width_p-1:3].
- Byte enables: sel_o = ((1<<bytes)-1) << off.
- Write data: the lowest `bytes` bytes of the forward data, replicated across all 64 bits. Bytes outside sel are don't-care but deterministic.
- Read data: dat_i shifted right by 8*off; its lowest `bytes` bytes are then replicated across 64 bits to form mem_rev_data_o.
- For writes, mem_rev_data_o = 0.
- ack_i seen outside BUS is ignored.
- Forward traffic is not accepted while in BUS or REV.
- Reset asserted in BUS or REV: next cycle is IDLE with cyc/stb/v = 0. The in-flight transaction is dropped with no reverse message.

Test Plan:
- Read, 8 bytes at addr 0x80000010. Bench acks after 2 cycles with dat_i=0x1122334455667788. Required: adr_o=0x10000002, sel_o=0xFF, we_o=0; then mem_rev_data_o=0x1122334455667788; header echoed exactly.
- Write, 1 byte at addr 0x80000003, data 0xAB. Required: sel_o=0x08, dat_o=0xABABABABABABABAB, we_o=1; one reverse beat.
- Read, 4 bytes at addr 0x...4, dat_i=0xDEADBEEF00000000. Required: mem_rev_data_o=0xDEADBEEFDEADBEEF.
- Backpressure: hold mem_rev_ready_and_i=0 for 5 cycles. Required: reverse header and data stable, mem_fwd_ready_and_o=0 throughout, one transfer on release.
- Delayed ack: no ack for 10 cycles. Required: cyc_o, stb_o, adr_o, sel_o stable; ack with late ack_i sampled in IDLE has no effect.
- Reset in BUS. Required: cyc_o=0 next cycle, no mem_rev_v_o; a new read afterwards completes normally.
